// File: rtl/divide_3_if.sv
// Request/result bundle for the word-serial divide-by-3 stage.
// The master issues start/in, and the slave returns out/done.
interface divide_3_if #(
  parameter int N = 128
);
  logic         start;
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic         done;

  modport master (output start, output in, input out, input done);
  modport slave  (input start, input in, output out, output done);
endinterface

// File: rtl/divide_3.sv
// Exact division by 3 modulo 2^N, using word-serial Hensel division (least significant word first).
// One W-bit word is processed per cycle. The only multiplier is by the constant 3^-1 mod 2^W.
module divide_3 #(
  parameter int N = 128,
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst,
  divide_3_if.slave  bus
);
  localparam int NW = N / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  // Newton iteration for 3^-1 mod 2^W; each step doubles the number of correct low bits.
  function automatic logic [W-1:0] inv3_f();
    logic [W-1:0] x;
    x = W'(3);
    for (int i = 0; i < 6; i++) x = x * (W'(2) - W'(3) * x);
    return x;
  endfunction

  localparam logic [W-1:0] INV3 = inv3_f();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_opnd;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_out;
  logic [1:0]    r_brw;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [W-1:0]  w_a;
  logic [W-1:0]  w_brw_ext;
  logic [W-1:0]  w_t;
  logic          w_b1;
  logic [W-1:0]  w_q;
  logic [W+1:0]  w_q3;
  logic [1:0]    w_brw_next;
  logic [N-1:0]  w_acc_next;
  logic          w_last;

  assign w_a        = r_opnd[W-1:0];
  assign w_brw_ext  = {{(W-2){1'b0}}, r_brw};
  assign w_t        = w_a - w_brw_ext;
  assign w_b1       = (w_a < w_brw_ext);
  assign w_q        = w_t * INV3;
  assign w_q3       = {2'b00, w_q} + {1'b0, w_q, 1'b0};
  // The new borrow is b1 plus the high part of 3*q. This sum never exceeds 2.
  assign w_brw_next = 2'(w_q3 >> W) + {1'b0, w_b1};
  assign w_acc_next = (r_acc >> W) | (N'(w_q) << (N - W));
  assign w_last     = (r_cnt == CW'(NW - 1));

  // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_brw   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_opnd  <= bus.in;
            r_acc   <= '0;
            r_brw   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_opnd <= r_opnd >> W;
          r_acc  <= w_acc_next;
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_out   <= w_acc_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.done = r_done;
endmodule

// File: tb/tb_divide_3.sv
// Directed and randomized checks of divide_3 (N=128, W=32) against (in * 3^-1) mod 2^128.
module tb_divide_3;
  localparam int N = 128;
  localparam logic [N-1:0] INV3_128 = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAB;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  divide_3_if #(.N(N)) bus ();

  divide_3 #(.N(N), .W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called 1 time unit after an edge. The start pulse is sampled at the next edge.
  task automatic start_op(input logic [N-1:0] v);
    bus.start = 1'b1;
    bus.in    = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 20);
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", lat);
    end
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] v, input logic [N-1:0] exp);
    int lat;
    start_op(v);
    check({nm, "_done_drop"}, N'(bus.done), N'(0));
    wait_done(lat);
    check({nm, "_latency"}, N'(lat), N'(4));
    check({nm, "_out"}, bus.out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] chain;
    int lat;

    vecs[0] = '{128'd3, 128'd1};
    vecs[1] = '{128'h3_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000};
    vecs[2] = '{~128'd2, ~128'd0};
    vecs[3] = '{128'd0 - 128'h30, 128'd0 - 128'd16};
    vecs[4] = '{128'd0, 128'd0};
    vecs[5] = '{128'd15, 128'd5};
    vecs[6] = '{128'd0 - 128'd9, 128'd0 - 128'd3};
    vecs[7] = '{128'h3_0000_0000, 128'h1_0000_0000};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", N'(bus.done), N'(0));
    check("reset_out", bus.out, '0);

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.in    = 128'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_over_start_done", N'(bus.done), N'(0));

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
    end

    // done and out hold while idle.
    run_op("in3", 128'd3, 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_done_%0d", i), N'(bus.done), N'(1));
      check($sformatf("hold_out_%0d", i), bus.out, 128'd1);
    end

    // Start from DONE: out keeps the prior result until the new one completes.
    run_op("in1", 128'd1, INV3_128);
    start_op(128'd9);
    check("restart_done_drop", N'(bus.done), N'(0));
    check("restart_out_held0", bus.out, INV3_128);
    @(posedge clk); #1;
    check("restart_out_held1", bus.out, INV3_128);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("restart_out_held3", bus.out, INV3_128);
    @(posedge clk); #1;
    check("restart_done", N'(bus.done), N'(1));
    check("restart_out", bus.out, 128'd3);

    // A start issued during RUN is ignored and is not queued.
    start_op(128'd21);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in    = 128'd300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("ignore_done_early", N'(bus.done), N'(0));
    @(posedge clk); #1;
    check("ignore_done_lat4", N'(bus.done), N'(1));
    check("ignore_out", bus.out, 128'd7);
    repeat (3) @(posedge clk);
    #1;
    check("ignore_not_queued_done", N'(bus.done), N'(1));
    check("ignore_not_queued_out", bus.out, 128'd7);

    // Reset during RUN aborts the operation, and the next operation completes normally.
    start_op(128'd30);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_done", N'(bus.done), N'(0));
    check("abort_out", bus.out, '0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_idle_done", N'(bus.done), N'(0));
    check("abort_idle_out", bus.out, '0);
    run_op("after_abort", 128'd6, 128'd2);

    // Random regression: odd iterations use multiples of 3.
    for (int i = 0; i < 1000; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      if (i % 2 == 1) v = v * 128'd3;
      start_op(v);
      wait_done(lat);
      check($sformatf("rand_%0d", i), bus.out, v * INV3_128);
    end

    // Chain into the divide-by-2 stage: 3*2^k -> 2^k -> 2^(k-1).
    for (int k = 1; k < 127; k++) begin
      v = 128'd3 << k;
      start_op(v);
      wait_done(lat);
      check($sformatf("pow_%0d", k), bus.out, 128'd1 << k);
      chain = bus.out >> 1;
      check($sformatf("chain_%0d", k), chain, 128'd1 << (k - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/divide_3.md
Name: divide_3

Overview:
- Exact division by 3 of an N-bit two's-complement integer, modulo 2^N.
- Sits directly upstream of divide_2 in the Toom-3 interpolation chain: interpolation value (r3 - r1) enters here, and the quotient feeds the subtract / divide-by-2 stage.
- Word-serial Hensel (LSW-first) algorithm: one W-bit word per cycle, no hardware divider. The only multiplier is a W-bit by constant.

Parameters:
- N, 128, total operand width in bits; must be a multiple of W.
- W, 32, word width processed per cycle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; samples in.
- in  input  N  dividend, two's complement, packed LSW at bits [W-1:0].
- out  output  N  quotient, valid while done=1.
- done  output  1  high when out holds the result of the most recent start; sticky until next accepted start or rst.

Behaviour:
- Constants:
  - NW = N/W.
  - INV3 = multiplicative inverse of 3 mod 2^W (0xAAAAAAAB for W=32).
- State: IDLE, RUN, DONE. Registers:
  - opnd: N-bit shift register.
  - acc: N-bit result shift register.
  - brw: borrow, 2 bits, range 0..2.
  - cnt: word index, 0..NW-1.
- Reset (rst=1 at an edge):
  - state=IDLE, out=0, done=0, brw=0, cnt=0.
  - Reset overrides start on the same edge.
- Accepting start:
  - Accepted in IDLE or DONE.
  - Latches in into opnd, clears brw, cnt and acc, sets done=0, goes to RUN.
  - out keeps its previous value until the new result completes.
- RUN, each cycle, with a = opnd word cnt:
  - t = (a - brw) mod 2^W.
  - b1 = 1 if a < brw, else 0.
  - q = (t * INV3) mod 2^W, low W bits only.
  - brw_next = b1 + floor(3*q / 2^W).
  - Store q as word cnt of acc; cnt++.
  - On cnt = NW-1: out <= acc with the final word inserted, done <= 1, state <= DONE.
- Latency: start sampled at edge 0 -> done=1 after edge NW (NW=4 for defaults). Throughput is one operation per NW+1 cycles, since start is only accepted in IDLE/DONE.
- start while in RUN: ignored. The operation in progress is not disturbed and the request is not queued.
- Result definition:
  - out = (in * 3^-1) mod 2^N for every input.
  - When in is divisible by 3 (signed or unsigned view), this equals the exact quotient in two's complement.
  - Non-divisible inputs give the Hensel value, not an error. No error flag.
- Final brw is discarded. There is no overflow output.
- rst mid-RUN: abort immediately into the reset state. The partial result is never presented on out.
- DONE holds out and done stable indefinitely.
- Arithmetic: brw never exceeds 2. The t*INV3 product is truncated to W bits, so a full 2W product is not required.

Test Plan:
- rst high 2 cycles, in=3, start pulse -> done rises exactly 4 cycles after the start edge; out=1; done stays high 10+ idle cycles with out stable.
- in = 0x3_0000_0000_0000_0000 (3*2^64) -> out = 0x1_0000_0000_0000_0000. Exercises the zero-word path and the upper-word quotient.
- in = 2^128 - 3 (-3) -> out = all ones (-1). in = 2^128 - 0x30 (-48) -> out = 2^128 - 16 (-16). Exercises borrow chaining across words.
- in = 1 (non-divisible) -> out = 0xAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAB. Then a second start with in=9 from DONE -> done drops next cycle, out stays at the prior value until done, then out=3.
- start re-pulsed 2 cycles into RUN with a different in -> ignored; result matches the first operand and latency is unchanged. rst asserted mid-RUN -> next cycle done=0, out=0, state IDLE; a following start completes normally.
- Random regression, 1000 operands (half pre-multiplied by 3): compare against the model (in * INV3_128) mod 2^128. Then chain into divide_2 with (3*2^k) inputs and check the end-to-end value 2^(k-1).
